// File: rtl/irrigation_pkg.sv
// Shared irrigation types and the per-zone sprinkler demand equation.
// Used by the multi-zone sequencer and the original single-zone logic.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Valve handshake: the sequencer has no handshake; valve is a level that
    // the drivers follow directly, abort is a single-cycle event pulse.

    // Water a zone when soil and air are both dry, or when soil is dry,
    // it is not cold and the supply is at least at middle level.
    function automatic logic sprinkler_demand(
        input logic earth,
        input logic air,
        input logic low_temp,
        input logic mid_water
    );
        return (!earth && !air) || (!earth && !low_temp && mid_water);
    endfunction

    // Zone index width; a single bit is kept even for degenerate sizes.
    function automatic int idx_width(input int zones);
        return (zones > 1) ? $clog2(zones) : 1;
    endfunction

endpackage

// File: rtl/zone_arbiter.sv
// Combinational round-robin search: first demanding zone at or after last+1,
// wrapping modulo ZONES.
module zone_arbiter
    import irrigation_pkg::*;
#(
    parameter int ZONES = 4,
    localparam int AW = idx_width(ZONES)
) (
    input  logic [ZONES-1:0] demand,
    input  logic [AW-1:0]    last,
    output logic             grant_valid,
    output logic [AW-1:0]    grant_idx
);

    int          off;
    logic [AW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        off         = 0;
        cand        = '0;
        for (int i = ZONES - 1; i >= 0; i--) begin
            off  = (int'(last) + 1 + i) % ZONES;
            cand = AW'(off);
            if (demand[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sprinkler_sequencer.sv
// Multi-zone sprinkler sequencer: serves demanding zones one at a time in
// round-robin order with a fixed run time and a pressure-recovery gap.
module sprinkler_sequencer
    import irrigation_pkg::*;
#(
    parameter int ZONES      = 4,
    parameter int RUN_CYCLES = 16,
    parameter int GAP_CYCLES = 4,
    localparam int AW = idx_width(ZONES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             water_fault,
    input  logic [ZONES-1:0] earth_humidity,
    input  logic [ZONES-1:0] air_humidity,
    input  logic             low_temperature,
    input  logic             mid_water_level,
    output logic [ZONES-1:0] valve,
    output logic [AW-1:0]    active_zone,
    output logic             busy,
    output logic             abort,
    output state_t           debug_state
);

    localparam int MAXC = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t RUN_LOAD = cnt_t'(RUN_CYCLES - 1);
    localparam cnt_t GAP_LOAD = cnt_t'(GAP_CYCLES - 1);

    state_t           state, state_d;
    cnt_t             cnt, cnt_d;
    logic [AW-1:0]    zone_q, zone_d;
    logic [AW-1:0]    last_q, last_d;
    logic [ZONES-1:0] valve_q, valve_d;
    logic             abort_q, abort_d;

    logic [ZONES-1:0] demand;
    logic             eligible;
    logic             grant_valid;
    logic [AW-1:0]    grant_idx;
    logic [ZONES-1:0] grant_onehot;

    always_comb begin
        demand = '0;
        for (int z = 0; z < ZONES; z++) begin
            demand[z] = sprinkler_demand(earth_humidity[z], air_humidity[z],
                                         low_temperature, mid_water_level);
        end
    end

    assign eligible     = enable & ~water_fault;
    assign grant_onehot = ZONES'(1) << grant_idx;

    zone_arbiter #(.ZONES(ZONES)) u_zone_arbiter (
        .demand      (demand),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            zone_q  <= '0;
            last_q  <= AW'(ZONES - 1);
            valve_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            zone_q  <= zone_d;
            last_q  <= last_d;
            valve_q <= valve_d;
            abort_q <= abort_d;
        end
    end

    // The counter is reloaded on every state entry, so it never wraps.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        zone_d  = zone_q;
        last_d  = last_q;
        valve_d = valve_q;
        abort_d = 1'b0;
        case (state)
            IDLE: begin
                if (eligible && grant_valid) begin
                    state_d = RUN;
                    cnt_d   = RUN_LOAD;
                    zone_d  = grant_idx;
                    valve_d = grant_onehot;
                end
            end
            RUN: begin
                // An early stop wins over a run ending on the same edge.
                if (!eligible || !demand[zone_q]) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    last_d  = zone_q;
                    valve_d = '0;
                    abort_d = 1'b1;
                end else if (cnt == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    last_d  = zone_q;
                    valve_d = '0;
                end else begin
                    cnt_d = cnt - cnt_t'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    zone_d  = '0;
                end else begin
                    cnt_d = cnt - cnt_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                zone_d  = '0;
                valve_d = '0;
            end
        endcase
    end

    // A fault closes the valves in the very cycle it is seen.
    assign valve       = valve_q & {ZONES{~water_fault}};
    assign active_zone = zone_q;
    assign busy        = (state == RUN) || (state == GAP);
    assign abort       = abort_q;
    assign debug_state = state;

endmodule
